addsub_pipe: RTL and testbench

ADDSUB_PIPE -- requirements
Module: addsub_pipe

---
 rtl/addsub_pkg.sv | 17 +
 rtl/addsub_slice.sv | 16 +
 rtl/addsub_pipe.sv | 140 ++++++++++++++
 tb/tb_addsub_pipe.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encoding and the
// width-independent control part of a pipeline beat.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Operand-width-dependent fields are appended by addsub_pipe, which knows N.
    typedef struct packed {
        logic valid;
        logic op;
        logic sgn;
        logic sat;
        logic carry;
    } beat_ctrl_t;

endpackage

// File: rtl/addsub_slice.sv
// Combinational CW-bit ripple adder slice with carry in and carry out.
module addsub_slice #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout
);

    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined N-bit add/subtract with the carry chain split over STAGES cycles.
// Optional saturation is enabled by defining ADDSUB_PIPE_SAT_EN.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         op,
    input  logic         sgn,
`ifdef ADDSUB_PIPE_SAT_EN
    input  logic         sat,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   s,
    output logic         ovf,
    output logic         neg,
    output logic         zero
);

    localparam int CW = N / STAGES;

    typedef struct packed {
        beat_ctrl_t ctrl;
        logic [N:0] sum;
        logic [N:0] opa;
        logic [N:0] opb;
    } beat_t;

    beat_t         stage_q [STAGES];
    beat_t         stage_d [STAGES];
    beat_t         src     [STAGES];
    beat_t         in_beat;
    logic [CW-1:0] slice_sum  [STAGES];
    logic          slice_cout [STAGES];
    logic [N:0]    a_ext;
    logic [N:0]    b_ext;
    logic [N:0]    res;
    logic          adv;
    logic          ovf_raw;

    assign adv      = !stage_q[STAGES-1].ctrl.valid || out_ready;
    assign in_ready = adv;

    // Subtraction is folded into the operands: invert b here, carry-in of 1.
    always_comb begin
        a_ext   = sgn ? {a[N-1], a} : {1'b0, a};
        b_ext   = sgn ? {b[N-1], b} : {1'b0, b};
        in_beat = '0;
        if (in_valid) begin
            in_beat.ctrl.valid = 1'b1;
            in_beat.ctrl.op    = op;
            in_beat.ctrl.sgn   = sgn;
`ifdef ADDSUB_PIPE_SAT_EN
            in_beat.ctrl.sat   = sat;
`else
            in_beat.ctrl.sat   = 1'b0;
`endif
            in_beat.ctrl.carry = (op == OP_SUB);
            in_beat.opa        = a_ext;
            in_beat.opb        = (op == OP_SUB) ? ~b_ext : b_ext;
        end
    end

    always_comb begin
        src[0] = in_beat;
        for (int k = 1; k < STAGES; k++) begin
            src[k] = stage_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        addsub_slice #(.CW(CW)) u_slice (
            .a    (src[k].opa[k*CW +: CW]),
            .b    (src[k].opb[k*CW +: CW]),
            .cin  (src[k].ctrl.carry),
            .sum  (slice_sum[k]),
            .cout (slice_cout[k])
        );
    end

    // Each stage resolves its own slice; the last one also produces the sign bit.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k] = stage_q[k];
            if (adv) begin
                stage_d[k]                    = src[k];
                stage_d[k].sum[k*CW +: CW]    = slice_sum[k];
                stage_d[k].ctrl.carry         = slice_cout[k];
                if (k == STAGES - 1) begin
                    stage_d[k].sum[N] = src[k].opa[N] ^ src[k].opb[N] ^ slice_cout[k];
                end
                if (!src[k].ctrl.valid) begin
                    stage_d[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    always_comb begin
        out_valid = stage_q[STAGES-1].ctrl.valid;
        ovf_raw   = stage_q[STAGES-1].ctrl.sgn
                    ? (stage_q[STAGES-1].sum[N] ^ stage_q[STAGES-1].sum[N-1])
                    : stage_q[STAGES-1].sum[N];
        res       = stage_q[STAGES-1].sum;
`ifdef ADDSUB_PIPE_SAT_EN
        // The true sign of an overflowed signed result is still s[N].
        if (stage_q[STAGES-1].ctrl.sat && ovf_raw) begin
            if (!stage_q[STAGES-1].ctrl.sgn) begin
                res = (stage_q[STAGES-1].ctrl.op == OP_SUB) ? '0 : {1'b0, {N{1'b1}}};
            end else begin
                res = stage_q[STAGES-1].sum[N] ? {2'b11, {(N-1){1'b0}}}
                                               : {2'b00, {(N-1){1'b1}}};
            end
        end
`endif
        s    = res;
        ovf  = out_valid && ovf_raw;
        neg  = out_valid && res[N];
        zero = out_valid && (res == '0);
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Randomized self-checking bench for addsub_pipe (N=8, STAGES=2) against a
// result-level pipeline model; honours ADDSUB_PIPE_SAT_EN when defined.
module tb_addsub_pipe;

    localparam int N      = 8;
    localparam int STAGES = 2;

    typedef struct packed {
        logic       valid;
        logic [8:0] s;
        logic       ovf;
        logic       neg;
        logic       zero;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         op;
    logic         sgn;
    logic         sat;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   s;
    logic         ovf;
    logic         neg;
    logic         zero;

    exp_t pipe [STAGES];
    int   n_checks;
    int   n_pass;
    int   n_accepted;
    int   n_delivered;

    addsub_pipe #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .sgn       (sgn),
`ifdef ADDSUB_PIPE_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .ovf       (ovf),
        .neg       (neg),
        .zero      (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Plain integer arithmetic on the true operand values.
    function automatic exp_t refModel(input logic [7:0] fa, input logic [7:0] fb,
                                      input logic fop, input logic fsgn, input logic fsat);
        int          ea;
        int          eb;
        int          r;
        logic [31:0] rv;
        exp_t        e;
        if (fsgn) begin
            ea = int'($signed(fa));
            eb = int'($signed(fb));
        end else begin
            ea = int'(fa);
            eb = int'(fb);
        end
        r     = fop ? (ea - eb) : (ea + eb);
        e.ovf = fsgn ? (r < -128 || r > 127) : (r < 0 || r > 255);
        if (fsat && e.ovf) begin
            if (fsgn) r = (r < 0) ? -128 : 127;
            else      r = (r < 0) ? 0 : 255;
        end
        rv      = r;
        e.s     = rv[8:0];
        e.neg   = e.s[8];
        e.zero  = (e.s == 9'h000);
        e.valid = 1'b1;
        return e;
    endfunction

    task automatic applyStimulus(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                                 input logic iop, input logic isgn, input logic isat,
                                 input logic ordy, input logic irst, output logic accepted);
        logic exp_adv;
        logic eff_sat;
        @(negedge clk);
        rst       = irst;
        in_valid  = v;
        a         = ia;
        b         = ib;
        op        = iop;
        sgn       = isgn;
        sat       = isat;
        out_ready = ordy;
        #1;
        exp_adv = !pipe[STAGES-1].valid || ordy;
        if (!irst) begin
            checkOutput("out_valid", 32'(out_valid), 32'(pipe[STAGES-1].valid));
            checkOutput("in_ready", 32'(in_ready), 32'(exp_adv));
            if (pipe[STAGES-1].valid) begin
                checkOutput("s", 32'(s), 32'(pipe[STAGES-1].s));
                checkOutput("ovf", 32'(ovf), 32'(pipe[STAGES-1].ovf));
                checkOutput("neg", 32'(neg), 32'(pipe[STAGES-1].neg));
                checkOutput("zero", 32'(zero), 32'(pipe[STAGES-1].zero));
                if (ordy) n_delivered++;
            end
        end
`ifdef ADDSUB_PIPE_SAT_EN
        eff_sat = isat;
`else
        eff_sat = 1'b0;
`endif
        accepted = 1'b0;
        if (irst) begin
            for (int k = 0; k < STAGES; k++) pipe[k] = '0;
        end else if (exp_adv) begin
            for (int k = STAGES - 1; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = v ? refModel(ia, ib, iop, isgn, eff_sat) : '0;
            if (v) begin
                accepted = 1'b1;
                n_accepted++;
            end
        end
    endtask

    initial begin
        logic       acc;
        logic [7:0] da [6];
        logic [7:0] db [6];
        logic       dop [6];
        logic       dsg [6];
        int         idx;

        n_checks    = 0;
        n_pass      = 0;
        n_accepted  = 0;
        n_delivered = 0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; sgn = 1'b0;
        sat = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < STAGES; k++) pipe[k] = '0;

        applyStimulus(0, 8'h00, 8'h00, 0, 0, 0, 1, 1, acc);
        applyStimulus(0, 8'h00, 8'h00, 0, 0, 0, 1, 1, acc);
        applyStimulus(0, 8'h00, 8'h00, 0, 0, 0, 1, 0, acc);
        checkOutput("reset_s", 32'(s), 32'h0);
        checkOutput("reset_ovf", 32'(ovf), 32'h0);
        checkOutput("reset_neg", 32'(neg), 32'h0);
        checkOutput("reset_zero", 32'(zero), 32'h0);

        // Directed corner cases, back to back.
        applyStimulus(1, 8'h03, 8'h05, 1, 0, 0, 1, 0, acc);
        applyStimulus(1, 8'hFF, 8'h01, 0, 0, 0, 1, 0, acc);
        applyStimulus(1, 8'hFF, 8'h01, 0, 1, 0, 1, 0, acc);
        applyStimulus(1, 8'h80, 8'h01, 1, 1, 0, 1, 0, acc);
        applyStimulus(1, 8'h7F, 8'h01, 0, 1, 0, 1, 0, acc);
`ifdef ADDSUB_PIPE_SAT_EN
        applyStimulus(1, 8'h7F, 8'h01, 0, 1, 1, 1, 0, acc);
        applyStimulus(1, 8'h03, 8'h05, 1, 0, 1, 1, 0, acc);
        applyStimulus(1, 8'h80, 8'h01, 1, 1, 1, 1, 0, acc);
        applyStimulus(1, 8'hFF, 8'hFF, 0, 0, 1, 1, 0, acc);
`endif
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 8'h00, 0, 0, 0, 1, 0, acc);

        // Six beats with the consumer stalled in cycles 3-7.
        for (int i = 0; i < 6; i++) begin
            da[i] = 8'($urandom); db[i] = 8'($urandom);
            dop[i] = 1'($urandom); dsg[i] = 1'($urandom);
        end
        idx = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            applyStimulus(idx < 6, da[idx % 6], db[idx % 6], dop[idx % 6], dsg[idx % 6], 0,
                          !(cyc >= 3 && cyc <= 7), 0, acc);
            if (acc) idx++;
        end
        checkOutput("stall_beats_accepted", 32'(idx), 32'd6);

        // Reset with two beats in flight.
        applyStimulus(1, 8'h11, 8'h22, 0, 0, 0, 1, 0, acc);
        applyStimulus(1, 8'h33, 8'h44, 1, 1, 0, 1, 0, acc);
        n_accepted -= 2;
        applyStimulus(0, 8'h00, 8'h00, 0, 0, 0, 1, 1, acc);
        applyStimulus(0, 8'h00, 8'h00, 0, 0, 0, 1, 0, acc);
        checkOutput("flush_s", 32'(s), 32'h0);
        checkOutput("flush_zero", 32'(zero), 32'h0);
        applyStimulus(1, 8'h10, 8'h20, 1, 1, 0, 1, 0, acc);
        applyStimulus(0, 8'h00, 8'h00, 0, 0, 0, 1, 0, acc);
        applyStimulus(0, 8'h00, 8'h00, 0, 0, 0, 1, 0, acc);

        // Random traffic with random back-pressure and mixed modes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom),
                          $urandom_range(0, 3) != 0, 0, acc);
        end
        for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 8'h00, 0, 0, 0, 1, 0, acc);
        checkOutput("beats_delivered", 32'(n_delivered), 32'(n_accepted));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
